hex_seg_mux: RTL and testbench

//   Drives a two-digit multiplexed 7-segment module (PmodSSD style).

---
 rtl/hex_seg_mux.sv | 76 +++++++
 tb/tb_hex_seg_mux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hex_seg_mux.sv
// Two-digit multiplexed 7-segment driver: shows hex_val as two hex digits on one
// shared segment bus, alternating digits every TOGGLE_CYCLES clocks with a blank gap.
module hex_seg_mux #(
    parameter int TOGGLE_CYCLES = 12000,
    parameter int BLANK_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hex_val,
    output logic       digit_sel,
    output logic [6:0] seg_pins
);

    localparam int CNT_W = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOGGLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             digit_sel_q, digit_sel_d;
    logic [6:0]       seg_pins_q, seg_pins_d;
    logic [3:0]       nibble;

    // Active-high segment patterns, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h3F;
            4'h1: enc = 7'h06;
            4'h2: enc = 7'h5B;
            4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;
            4'h5: enc = 7'h6D;
            4'h6: enc = 7'h7D;
            4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;
            4'h9: enc = 7'h6F;
            4'hA: enc = 7'h77;
            4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;
            4'hD: enc = 7'h5E;
            4'hE: enc = 7'h79;
            default: enc = 7'h71;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cnt_d       = cnt_q + CNT_W'(1);
        digit_sel_d = digit_sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            digit_sel_d = ~digit_sel_q;
        end
        // Segments follow next-state values so they switch on the same edge as digit_sel.
        nibble     = digit_sel_d ? hex_val[7:4] : hex_val[3:0];
        seg_pins_d = enc(nibble);
        if ((BLANK_CYCLES > 0) && (cnt_d < BLANK_LIM))
            seg_pins_d = 7'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            digit_sel_q <= 1'b0;
            seg_pins_q  <= 7'h00;
        end else begin
            cnt_q       <= cnt_d;
            digit_sel_q <= digit_sel_d;
            seg_pins_q  <= seg_pins_d;
        end
    end

    assign digit_sel = digit_sel_q;
    assign seg_pins  = seg_pins_q;

endmodule

// File: tb/tb_hex_seg_mux.sv
// Self-checking bench for hex_seg_mux (TOGGLE_CYCLES=8, BLANK_CYCLES=2): expected
// outputs are queued as each input is driven and popped after the clock edge.
module tb_hex_seg_mux;

    localparam int TOG = 8;
    localparam int BLK = 2;

    logic       clk;
    logic       rst;
    logic [7:0] hex_val;
    logic       digit_sel;
    logic [6:0] seg_pins;

    int tests = 0;
    int fails = 0;
    int k     = 0;          // clock edges since reset release
    int last_toggle = 0;
    logic prev_sel = 1'b0;
    logic [7:0] exp_q [$];  // {digit_sel, seg_pins}

    hex_seg_mux #(.TOGGLE_CYCLES(TOG), .BLANK_CYCLES(BLK)) dut (
        .clk       (clk),
        .rst       (rst),
        .hex_val   (hex_val),
        .digit_sel (digit_sel),
        .seg_pins  (seg_pins)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected output after edge number e (counted from reset release) with input h.
    function automatic logic [7:0] model(input int e, input logic [7:0] h);
        int   pos  = e % (2 * TOG);
        logic sel  = (pos >= TOG);
        int   ph   = pos % TOG;
        logic [6:0] s = (ph < BLK) ? 7'h00 : seg_ref(sel ? h[7:4] : h[3:0]);
        return {sel, s};
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, k);
        end
    endtask

    // Drive one input value, queue its expectation, clock, then compare.
    task automatic tick(input logic [7:0] h, input string tag);
        logic [7:0] e;
        hex_val = h;
        exp_q.push_back(model(k + 1, h));
        @(posedge clk);
        k++;
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, {digit_sel, seg_pins});
        end else begin
            e = exp_q.pop_front();
            check8(tag, {digit_sel, seg_pins}, e);
        end
        check8({tag, "_noX"}, 8'($isunknown({digit_sel, seg_pins})), 8'h00);
        if (digit_sel !== prev_sel) begin
            check8({tag, "_toggle_gap"}, 8'(k - last_toggle), 8'(TOG));
            last_toggle = k;
            prev_sel    = digit_sel;
        end
    endtask

    // Advance with the held value until the next edge will be number p within the period.
    task automatic sync_to(input int p);
        while (((k + 1) % (2 * TOG)) != p) tick(hex_val, "sync");
    endtask

    task automatic release_reset;
        rst         = 1'b0;
        k           = 0;
        last_toggle = 0;
        prev_sel    = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        hex_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check8("reset_state", {digit_sel, seg_pins}, 8'h00);
        release_reset();

        // After release: one blank edge, then the low digit.
        tick(8'h00, "post_reset_blank");
        check8("post_reset_blank_direct", {1'b0, seg_pins}, 8'h00);
        tick(8'h00, "post_reset_zero");
        check8("post_reset_zero_direct", {1'b0, seg_pins}, 8'h3F);

        // Mux timing over two full periods with 0x1A.
        repeat (4 * TOG) tick(8'h1A, "mux_1A");

        // Encoding sweep: each nibble held a full period on both digits.
        for (int n = 0; n < 16; n++) begin
            logic [3:0] lo = 4'(n);
            logic [3:0] hi = ~lo;
            repeat (2 * TOG) tick({hi, lo}, "enc_sweep");
        end
        sync_to(3);
        tick(8'hBD, "enc_d");
        check8("enc_d_direct", {1'b0, seg_pins}, 8'h5E);
        sync_to(TOG + 3);
        tick(8'hBD, "enc_b");
        check8("enc_b_direct", {1'b0, seg_pins}, 8'h7C);

        // Live update mid-lit window of the low digit.
        sync_to(3);
        tick(8'h12, "live_12");
        check8("live_12_direct", {1'b0, seg_pins}, 8'h5B);
        tick(8'h34, "live_34");
        check8("live_34_direct", {1'b0, seg_pins}, 8'h66);

        // Change the value inside the blank window of the high digit.
        sync_to(TOG);
        tick(8'h56, "blank_0");
        check8("blank_0_direct", {digit_sel, seg_pins}, 8'h80);
        tick(8'h78, "blank_1");
        check8("blank_1_direct", {digit_sel, seg_pins}, 8'h80);
        tick(8'h9C, "blank_end");
        check8("blank_end_direct", {digit_sel, seg_pins}, {1'b1, 7'h6F});

        // Long run with random data.
        repeat (1000) tick(8'($urandom_range(0, 255)), "random");

        // Reset in the middle of a lit high-digit window, checked without a clock edge.
        sync_to(TOG + 4);
        tick(8'hFF, "pre_mid_reset");
        rst = 1'b1;
        #1;
        check8("mid_reset_async", {digit_sel, seg_pins}, 8'h00);
        @(posedge clk);
        #1;
        release_reset();
        tick(8'h00, "restart_blank");
        tick(8'h00, "restart_low");
        repeat (2 * TOG) tick(8'hE5, "restart_run");

        check8("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
